// File: rtl/hpdcache_rrarb_burst.sv
// Round-robin arbiter with grant locking for multi-beat transactions.
// A winner keeps the downstream port until its beat flagged last is accepted,
// so bursts from different requesters are never interleaved.
module hpdcache_rrarb_burst #(
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_BEATS = 16,
  localparam int unsigned IdW      = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned BeatW    = $clog2(MAX_BEATS + 1) + 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_i,
  input  logic [N-1:0]   last_i,
  input  logic           ready_i,
  output logic [N-1:0]   gnt_o,
  output logic [IdW-1:0] gnt_id_o,
  output logic           busy_o,
  output logic           err_o
);

  logic             lock_q, lock_d;
  logic [IdW-1:0]   owner_q, owner_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [BeatW-1:0] beats_q, beats_d;
  logic             err_q, err_d;

  logic [IdW-1:0]   win;
  logic             found;
  logic [IdW:0]     idx;
  logic             any_gnt;
  logic             acc;
  logic             lst;

  // Successor of an id with wrap from N-1 back to 0.
  function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
    if (id == IdW'(N - 1)) begin
      return '0;
    end
    return id + IdW'(1);
  endfunction

  // Round-robin scan starting at ptr_q; first requesting index wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (IdW + 1)'(k);
      if (idx >= (IdW + 1)'(N)) begin
        idx = idx - (IdW + 1)'(N);
      end
      if (!found && req_i[idx[IdW-1:0]]) begin
        found = 1'b1;
        win   = idx[IdW-1:0];
      end
    end
  end

  // Grant: locked owner only (and only while it requests), else the scan winner.
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    if (lock_q) begin
      if (req_i[owner_q]) begin
        gnt_o[owner_q] = 1'b1;
        gnt_id_o       = owner_q;
      end
    end else if (found) begin
      gnt_o[win] = 1'b1;
      gnt_id_o   = win;
    end
  end

  assign any_gnt = |gnt_o;
  assign acc     = any_gnt & ready_i;
  assign lst     = last_i[gnt_id_o];

  // Lock/pointer/beat-count next state; ready_i only reaches state, never gnt_o.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    beats_d = beats_q;
    err_d   = 1'b0;

    if (!lock_q) begin
      if (any_gnt) begin
        if (acc && lst) begin
          ptr_d = next_id(gnt_id_o);
        end else begin
          // Lock even when not accepted so the shown grant cannot move.
          lock_d  = 1'b1;
          owner_d = gnt_id_o;
        end
      end
    end else if (acc && lst) begin
      lock_d = 1'b0;
      ptr_d  = next_id(owner_q);
    end

    if (acc && lst) begin
      beats_d = '0;
    end else if (acc) begin
      if (beats_q != {BeatW{1'b1}}) begin
        beats_d = beats_q + BeatW'(1);
      end
      // Only the crossing into MAX_BEATS pulses; later beats are already past it.
      err_d = (beats_q == BeatW'(MAX_BEATS - 1));
    end
  end

  // State registers with synchronous reset; reset aborts any burst in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      beats_q <= '0;
      err_q   <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
      err_q   <= err_d;
    end
  end

  assign busy_o = lock_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_hpdcache_rrarb_burst.sv
// Self-checking bench for hpdcache_rrarb_burst: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_hpdcache_rrarb_burst;

  localparam int NR   = 4;
  localparam int MAXB = 4;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR-1:0] last;
  logic          ready;
  logic [NR-1:0] gnt;
  logic [1:0]    gnt_id;
  logic          busy;
  logic          err;

  int tests;
  int fails;

  // Reference model state
  bit m_valid;
  bit m_lock;
  int m_owner;
  int m_ptr;
  int m_cnt;
  bit m_err;
  int exp_g;

  hpdcache_rrarb_burst #(
    .N         (NR),
    .MAX_BEATS (MAXB)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .last_i   (last),
    .ready_i  (ready),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .busy_o   (busy),
    .err_o    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Granted index per the arbitration rules, or -1 when nothing is granted.
  function automatic int model_grant();
    if (m_lock) begin
      return req[m_owner] ? m_owner : -1;
    end
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  // Apply inputs for one cycle and compare outputs with the model.
  task automatic drive(input logic r, input logic [NR-1:0] q, input logic [NR-1:0] l,
                       input logic rd);
    rst   = r;
    req   = q;
    last  = l;
    ready = rd;
    #1;
    exp_g = model_grant();
    if (m_valid) begin
      chk("gnt", 32'(gnt), (exp_g < 0) ? 32'd0 : (32'd1 << exp_g));
      chk("gnt_id", 32'(gnt_id), (exp_g < 0) ? 32'd0 : 32'(exp_g));
      chk("busy", 32'(busy), 32'(m_lock));
      chk("err", 32'(err), 32'(m_err));
    end
  endtask

  // Advance one clock and update the model from the inputs of that cycle.
  task automatic tick();
    bit acc;
    bit done;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b1;
      m_lock  = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      m_cnt   = 0;
      m_err   = 1'b0;
    end else begin
      acc   = (exp_g >= 0) && ready;
      done  = acc && last[exp_g];
      m_err = acc && !done && (m_cnt + 1 == MAXB);
      if (done) begin
        m_cnt  = 0;
        m_lock = 1'b0;
        m_ptr  = (exp_g + 1) % NR;
      end else begin
        if (acc) m_cnt++;
        if (exp_g >= 0) begin
          m_lock  = 1'b1;
          m_owner = exp_g;
        end
      end
    end
    #1;
  endtask

  int seq_id[5] = '{0, 1, 2, 3, 0};

  initial begin
    logic          r;
    logic [NR-1:0] q;
    logic [NR-1:0] l;
    logic          rd;
    tests   = 0;
    fails   = 0;
    m_valid = 1'b0;
    rst = 1'b1; req = '0; last = '0; ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset
    drive(1'b1, 4'b0000, 4'b0000, 1'b0); tick();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    tick();

    // All requesting, single-beat: grants rotate 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'b1111, 4'b1111, 1'b1);
      chk("rot_id", 32'(gnt_id), 32'(seq_id[i]));
      chk("rot_busy", 32'(busy), 32'd0);
      tick();
    end

    // Unaccepted grant stays fixed and locks until accepted
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b0110, 4'b0010, (i == 3) ? 1'b1 : 1'b0);
      chk("hold_gnt", 32'(gnt), 32'h2);
      if (i > 0) chk("hold_busy", 32'(busy), 32'd1);
      tick();
    end

    // Requester 2: three-beat burst while everyone requests
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1111, (i == 2) ? 4'b0100 : 4'b0000, 1'b1);
      chk("burst_gnt", 32'(gnt), 32'h4);
      tick();
    end
    drive(1'b0, 4'b1111, 4'b1111, 1'b1);
    chk("after_burst_id", 32'(gnt_id), 32'd3);
    tick();

    // Requester 0: six beats, err after fourth accept, lock held to the end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 4'b0001, (i == 5) ? 4'b0001 : 4'b0000, 1'b1);
      chk("long_gnt", 32'(gnt), 32'h1);
      if (i == 4) chk("long_err", 32'(err), 32'd1);
      if (i > 0) chk("long_busy", 32'(busy), 32'd1);
      tick();
    end
    drive(1'b0, 4'b0000, 4'b0000, 1'b1);
    chk("long_err_gone", 32'(err), 32'd0);
    tick();

    // Owner 1 drops its request mid-burst; requester 3 must not be granted
    drive(1'b0, 4'b0010, 4'b0000, 1'b1); tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'b1000, 4'b0000, 1'b1);
      chk("gap_gnt", 32'(gnt), 32'd0);
      chk("gap_busy", 32'(busy), 32'd1);
      tick();
    end
    drive(1'b0, 4'b1010, 4'b0010, 1'b1);
    chk("resume_gnt", 32'(gnt), 32'h2);
    tick();

    // Reset mid-burst of requester 3
    drive(1'b0, 4'b1000, 4'b0000, 1'b1); tick();
    drive(1'b0, 4'b1000, 4'b0000, 1'b1); tick();
    drive(1'b1, 4'b1000, 4'b0000, 1'b1); tick();
    drive(1'b0, 4'b1001, 4'b0000, 1'b0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_id", 32'(gnt_id), 32'd0);
    tick();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      r  = ($urandom_range(0, 59) == 0);
      q  = NR'($urandom);
      l  = '0;
      for (int b = 0; b < NR; b++) l[b] = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 3) != 0);
      drive(r, q, l, rd);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
